exe_stage: RTL and testbench

Execute stage of the 5-stage ARM pipeline. Consumes the ID/EX pipeline register outputs and computes Val2 (immediate rotate or register shift). Runs the ALU and produces the branch target. Holds the NZCV status register and registers the ALU result plus control into an internal EXE/MEM pipeline register feeding the memory stage.

---
 rtl/exe_stage_pkg.sv | 31 +++
 rtl/exe_stage_alu.sv | 53 +++++
 rtl/exe_stage.sv | 112 +++++++++++
 tb/tb_exe_stage.sv | 266 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/exe_stage_pkg.sv
// Shared widths and encodings for the execute stage.
// ALU command and shift-type codes match the decode stage.
package exe_stage_pkg;

  localparam int ADDRESS_LEN          = 32;
  localparam int REGISTER_LEN         = 32;
  localparam int EXECUTE_COMMAND_LEN  = 4;
  localparam int REG_ADDRESS_LEN      = 4;
  localparam int SIGNED_IMMEDIATE_LEN = 24;
  localparam int SHIFT_OPERAND_LEN    = 12;

  typedef enum logic [3:0] {
    EXE_MOV = 4'b0001,
    EXE_ADD = 4'b0010,
    EXE_ADC = 4'b0011,
    EXE_SUB = 4'b0100,
    EXE_SBC = 4'b0101,
    EXE_AND = 4'b0110,
    EXE_ORR = 4'b0111,
    EXE_EOR = 4'b1000,
    EXE_MVN = 4'b1001
  } exe_cmd_e;

  typedef enum logic [1:0] {
    SH_LSL = 2'b00,
    SH_LSR = 2'b01,
    SH_ASR = 2'b10,
    SH_ROR = 2'b11
  } shift_e;

endpackage

// File: rtl/exe_stage_alu.sv
// Execute-stage ALU: result plus NZCV flags.
// Logic and move ops pass the incoming C and V through.
module exe_stage_alu
  import exe_stage_pkg::*;
#(
  parameter int W = REGISTER_LEN
) (
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  input  logic [3:0]   cmd,
  input  logic [1:0]   cv_in,
  output logic [W-1:0] res,
  output logic [3:0]   flags
);

  logic [W:0] sum;
  logic       c;
  logic       v;
  logic       cin;

  always_comb begin
    sum = '0;
    res = '0;
    c   = cv_in[1];
    v   = cv_in[0];
    cin = 1'b0;
    case (cmd)
      EXE_MOV: res = b;
      EXE_MVN: res = ~b;
      EXE_ADD, EXE_ADC: begin
        cin = (cmd == EXE_ADC) && cv_in[1];
        sum = {1'b0, a} + {1'b0, b} + {{W{1'b0}}, cin};
        res = sum[W-1:0];
        c   = sum[W];
        v   = (a[W-1] == b[W-1]) && (res[W-1] != a[W-1]);
      end
      EXE_SUB, EXE_SBC: begin
        // SBC subtracts the inverted carry as a borrow
        cin = (cmd == EXE_SBC) && !cv_in[1];
        sum = {1'b0, a} - {1'b0, b} - {{W{1'b0}}, cin};
        res = sum[W-1:0];
        c   = ~sum[W];
        v   = (a[W-1] != b[W-1]) && (res[W-1] != a[W-1]);
      end
      EXE_AND: res = a & b;
      EXE_ORR: res = a | b;
      EXE_EOR: res = a ^ b;
      default: res = '0;
    endcase
    flags = {res[W-1], res == '0, c, v};
  end

endmodule

// File: rtl/exe_stage.sv
// Execute stage: Val2 shifter, ALU, branch target,
// NZCV status register and the EXE/MEM pipeline register.
module exe_stage
  import exe_stage_pkg::*;
#(
  parameter int ADDRESS_LEN          = 32,
  parameter int REGISTER_LEN         = 32,
  parameter int EXECUTE_COMMAND_LEN  = 4,
  parameter int REG_ADDRESS_LEN      = 4,
  parameter int SIGNED_IMMEDIATE_LEN = 24,
  parameter int SHIFT_OPERAND_LEN    = 12
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic                            freeze,
  input  logic                            mem_read_en_in,
  input  logic                            mem_write_en_in,
  input  logic                            wb_enable_in,
  input  logic                            immediate_in,
  input  logic                            branch_taken_in,
  input  logic                            status_write_enable_in,
  input  logic [ADDRESS_LEN-1:0]          PC_in,
  input  logic [EXECUTE_COMMAND_LEN-1:0]  execute_command_in,
  input  logic [REGISTER_LEN-1:0]         reg_file_in1,
  input  logic [REGISTER_LEN-1:0]         reg_file_in2,
  input  logic [REG_ADDRESS_LEN-1:0]      dest_reg_in,
  input  logic [SIGNED_IMMEDIATE_LEN-1:0] signed_immediate_in,
  input  logic [SHIFT_OPERAND_LEN-1:0]    shift_operand_in,
  input  logic [3:0]                      status_reg_in,
  output logic                            branch_taken_out,
  output logic [ADDRESS_LEN-1:0]          branch_address,
  output logic [3:0]                      status_out,
  output logic                            mem_read_en_out,
  output logic                            mem_write_en_out,
  output logic                            wb_enable_out,
  output logic [REGISTER_LEN-1:0]         alu_result_out,
  output logic [REGISTER_LEN-1:0]         store_value_out,
  output logic [REG_ADDRESS_LEN-1:0]      dest_reg_out
);

  localparam int W = REGISTER_LEN;

  logic [W-1:0]   val2;
  logic [W-1:0]   alu_res;
  logic [3:0]     flags;
  logic [2*W-1:0] imm_rot;
  logic [2*W-1:0] rm_rot;
  logic [4:0]     amt;

  always_comb begin
    amt     = shift_operand_in[11:7];
    // rotate by shifting a doubled copy right
    imm_rot = {2{{{(W-8){1'b0}}, shift_operand_in[7:0]}}}
              >> {shift_operand_in[11:8], 1'b0};
    rm_rot  = {2{reg_file_in2}} >> amt;
    val2    = reg_file_in2;
    if (immediate_in) begin
      val2 = imm_rot[W-1:0];
    end else if (mem_read_en_in || mem_write_en_in) begin
      val2 = {{(W-SHIFT_OPERAND_LEN){1'b0}}, shift_operand_in};
    end else begin
      unique case (shift_e'(shift_operand_in[6:5]))
        SH_LSL: val2 = reg_file_in2 << amt;
        SH_LSR: val2 = reg_file_in2 >> amt;
        SH_ASR: val2 = $unsigned($signed(reg_file_in2) >>> amt);
        SH_ROR: val2 = rm_rot[W-1:0];
        default: val2 = reg_file_in2;
      endcase
    end
  end

  exe_stage_alu #(.W(W)) u_alu (
    .a     (reg_file_in1),
    .b     (val2),
    .cmd   (execute_command_in),
    .cv_in (status_reg_in[1:0]),
    .res   (alu_res),
    .flags (flags)
  );

  assign branch_taken_out = branch_taken_in;
  assign branch_address   = PC_in + ({{(ADDRESS_LEN-SIGNED_IMMEDIATE_LEN)
                            {signed_immediate_in[SIGNED_IMMEDIATE_LEN-1]}},
                            signed_immediate_in} << 2);

  always_ff @(posedge clk) begin
    if (rst) begin
      status_out <= '0;
    end else if (status_write_enable_in && !freeze) begin
      status_out <= flags;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      mem_read_en_out  <= 1'b0;
      mem_write_en_out <= 1'b0;
      wb_enable_out    <= 1'b0;
      alu_result_out   <= '0;
      store_value_out  <= '0;
      dest_reg_out     <= '0;
    end else if (!freeze) begin
      mem_read_en_out  <= mem_read_en_in;
      mem_write_en_out <= mem_write_en_in;
      wb_enable_out    <= wb_enable_in;
      alu_result_out   <= alu_res;
      store_value_out  <= reg_file_in2;
      dest_reg_out     <= dest_reg_in;
    end
  end

endmodule

// File: tb/tb_exe_stage.sv
// Self-checking bench for exe_stage: directed cases plus
// randomized traffic against a behavioural model.
module tb_exe_stage;

  logic        clk = 1'b0;
  logic        rst, freeze;
  logic        mem_read_en_in, mem_write_en_in, wb_enable_in;
  logic        immediate_in, branch_taken_in, status_write_enable_in;
  logic [31:0] PC_in;
  logic [3:0]  execute_command_in;
  logic [31:0] reg_file_in1, reg_file_in2;
  logic [3:0]  dest_reg_in;
  logic [23:0] signed_immediate_in;
  logic [11:0] shift_operand_in;
  logic [3:0]  status_reg_in;
  logic        branch_taken_out;
  logic [31:0] branch_address;
  logic [3:0]  status_out;
  logic        mem_read_en_out, mem_write_en_out, wb_enable_out;
  logic [31:0] alu_result_out, store_value_out;
  logic [3:0]  dest_reg_out;

  always #5 clk = ~clk;

  exe_stage dut (
    .clk                    (clk),
    .rst                    (rst),
    .freeze                 (freeze),
    .mem_read_en_in         (mem_read_en_in),
    .mem_write_en_in        (mem_write_en_in),
    .wb_enable_in           (wb_enable_in),
    .immediate_in           (immediate_in),
    .branch_taken_in        (branch_taken_in),
    .status_write_enable_in (status_write_enable_in),
    .PC_in                  (PC_in),
    .execute_command_in     (execute_command_in),
    .reg_file_in1           (reg_file_in1),
    .reg_file_in2           (reg_file_in2),
    .dest_reg_in            (dest_reg_in),
    .signed_immediate_in    (signed_immediate_in),
    .shift_operand_in       (shift_operand_in),
    .status_reg_in          (status_reg_in),
    .branch_taken_out       (branch_taken_out),
    .branch_address         (branch_address),
    .status_out             (status_out),
    .mem_read_en_out        (mem_read_en_out),
    .mem_write_en_out       (mem_write_en_out),
    .wb_enable_out          (wb_enable_out),
    .alu_result_out         (alu_result_out),
    .store_value_out        (store_value_out),
    .dest_reg_out           (dest_reg_out)
  );

  int n_checks = 0;
  int n_fail   = 0;

  logic [31:0] m_res, m_store;
  logic [3:0]  m_dest, m_status;
  logic        m_mr, m_mw, m_wb;

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] m_val2();
    logic [31:0] v;
    int amt;
    if (immediate_in) begin
      v = {24'd0, shift_operand_in[7:0]};
      for (int i = 0; i < 2 * int'(shift_operand_in[11:8]); i++)
        v = (v >> 1) | ((v & 32'd1) << 31);
    end else if (mem_read_en_in || mem_write_en_in) begin
      v = {20'd0, shift_operand_in};
    end else begin
      v = reg_file_in2;
      amt = int'(shift_operand_in[11:7]);
      for (int i = 0; i < amt; i++) begin
        case (shift_operand_in[6:5])
          2'd0: v = v << 1;
          2'd1: v = v >> 1;
          2'd2: v = (v >> 1) | (v & 32'h8000_0000);
          default: v = (v >> 1) | ((v & 32'd1) << 31);
        endcase
      end
    end
    return v;
  endfunction

  task automatic m_alu(input logic [31:0] a, input logic [31:0] b,
                       input logic [3:0] cmd, input logic [3:0] st,
                       output logic [31:0] res, output logic [3:0] fl);
    longint u, s, k;
    logic c, v;
    c = st[1];
    v = st[0];
    res = 32'd0;
    case (cmd)
      4'd1: res = b;
      4'd9: res = ~b;
      4'd2, 4'd3: begin
        k = (cmd == 4'd3 && st[1]) ? 64'sd1 : 64'sd0;
        u = longint'(a) + longint'(b) + k;
        s = longint'($signed(a)) + longint'($signed(b)) + k;
        res = u[31:0];
        c = (u >= 64'sh1_0000_0000);
        v = (s > 64'sd2147483647) || (s < -64'sd2147483648);
      end
      4'd4, 4'd5: begin
        k = (cmd == 4'd5 && !st[1]) ? 64'sd1 : 64'sd0;
        u = longint'(a) - longint'(b) - k;
        s = longint'($signed(a)) - longint'($signed(b)) - k;
        res = u[31:0];
        c = (u >= 0);
        v = (s > 64'sd2147483647) || (s < -64'sd2147483648);
      end
      4'd6: res = a & b;
      4'd7: res = a | b;
      4'd8: res = a ^ b;
      default: res = 32'd0;
    endcase
    fl = {res[31], res == 32'd0, c, v};
  endtask

  task automatic model_step();
    logic [31:0] r;
    logic [3:0]  f;
    m_alu(reg_file_in1, m_val2(), execute_command_in, status_reg_in, r, f);
    if (rst) begin
      m_res = 0; m_store = 0; m_dest = 0; m_status = 0;
      m_mr = 0; m_mw = 0; m_wb = 0;
    end else if (!freeze) begin
      m_res = r; m_store = reg_file_in2; m_dest = dest_reg_in;
      m_mr = mem_read_en_in; m_mw = mem_write_en_in; m_wb = wb_enable_in;
      if (status_write_enable_in) m_status = f;
    end
  endtask

  task automatic check_model();
    int off;
    logic [31:0] eb;
    off = int'(signed_immediate_in);
    if (off >= (1 << 23)) off = off - (1 << 24);
    eb = PC_in + 32'(off * 4);
    chk("res", alu_result_out, m_res);
    chk("store", store_value_out, m_store);
    chk("dest", 32'(dest_reg_out), 32'(m_dest));
    chk("status", 32'(status_out), 32'(m_status));
    chk("mr", 32'(mem_read_en_out), 32'(m_mr));
    chk("mw", 32'(mem_write_en_out), 32'(m_mw));
    chk("wb", 32'(wb_enable_out), 32'(m_wb));
    chk("br_addr", branch_address, eb);
    chk("br_taken", 32'(branch_taken_out), 32'(branch_taken_in));
  endtask

  task automatic tick();
    @(posedge clk);
    model_step();
    @(negedge clk);
    check_model();
  endtask

  task automatic set_op(input logic [3:0] cmd, input logic imm,
                        input logic mr, input logic mw, input logic s,
                        input logic [31:0] rn, input logic [31:0] rm,
                        input logic [11:0] op, input logic [3:0] st);
    execute_command_in = cmd;
    immediate_in = imm;
    mem_read_en_in = mr;
    mem_write_en_in = mw;
    wb_enable_in = !mw;
    status_write_enable_in = s;
    reg_file_in1 = rn;
    reg_file_in2 = rm;
    shift_operand_in = op;
    status_reg_in = st;
    dest_reg_in = 4'($urandom);
  endtask

  initial begin
    rst = 1; freeze = 0;
    PC_in = 32'h40; signed_immediate_in = 24'h10; branch_taken_in = 0;
    set_op(4'd2, 1'b1, 1'b1, 1'b0, 1'b1, 32'h1234, 32'h55, 12'h0ff, 4'hf);
    tick();
    tick();
    chk("rst_res", alu_result_out, 32'h0);
    chk("rst_status", 32'(status_out), 32'h0);
    chk("rst_mr", 32'(mem_read_en_out), 32'h0);
    chk("rst_wb", 32'(wb_enable_out), 32'h0);
    rst = 0;

    set_op(4'd2, 1'b1, 1'b0, 1'b0, 1'b1, 32'h7fff_ffff, 32'h0, 12'h001, 4'h0);
    tick();
    chk("add_ovf_res", alu_result_out, 32'h8000_0000);
    chk("add_ovf_nzcv", 32'(status_out), 32'h9);

    set_op(4'd4, 1'b0, 1'b0, 1'b0, 1'b1, 32'd5, 32'd5, 12'h000, 4'h0);
    tick();
    chk("subs_res", alu_result_out, 32'h0);
    chk("subs_nzcv", 32'(status_out), 32'h6);

    set_op(4'd3, 1'b1, 1'b0, 1'b0, 1'b0, 32'd1, 32'd0, 12'h001, 4'h2);
    tick();
    chk("adc_res", alu_result_out, 32'd3);

    set_op(4'd1, 1'b1, 1'b0, 1'b0, 1'b0, 32'd0, 32'd0, 12'h4ff, 4'h0);
    tick();
    chk("imm_rot", alu_result_out, 32'hff00_0000);

    set_op(4'd1, 1'b0, 1'b0, 1'b0, 1'b0, 32'd0, 32'h8000_0000, 12'h240, 4'h0);
    tick();
    chk("asr4", alu_result_out, 32'hf800_0000);

    set_op(4'd2, 1'b0, 1'b1, 1'b0, 1'b0, 32'h1000, 32'd0, 12'hffc, 4'h0);
    tick();
    chk("ldr_addr", alu_result_out, 32'h0000_1ffc);
    chk("ldr_mr", 32'(mem_read_en_out), 32'h1);

    freeze = 1;
    for (int i = 0; i < 3; i++) begin
      set_op(4'd2, 1'b1, 1'b0, 1'b0, 1'b1, $urandom, $urandom,
             12'($urandom), 4'($urandom));
      tick();
      chk("frz_res", alu_result_out, 32'h0000_1ffc);
      chk("frz_status", 32'(status_out), 32'h6);
      chk("frz_mr", 32'(mem_read_en_out), 32'h1);
    end
    freeze = 0;
    set_op(4'd2, 1'b1, 1'b0, 1'b0, 1'b1, 32'd2, 32'd0, 12'h003, 4'h0);
    chk("unfrz_hold", alu_result_out, 32'h0000_1ffc);
    tick();
    chk("unfrz_res", alu_result_out, 32'd5);
    chk("unfrz_status", 32'(status_out), 32'h0);

    PC_in = 32'h100; signed_immediate_in = 24'hff_fffe; branch_taken_in = 1;
    #1;
    chk("br_back", branch_address, 32'h0000_00f8);
    chk("br_taken1", 32'(branch_taken_out), 32'h1);
    branch_taken_in = 0;
    #1;
    chk("br_taken0", 32'(branch_taken_out), 32'h0);

    for (int i = 0; i < 400; i++) begin
      rst = ($urandom_range(0, 31) == 0);
      freeze = ($urandom_range(0, 4) == 0);
      set_op(4'($urandom_range(0, 15)), 1'($urandom), 1'($urandom_range(0, 3) == 0),
             1'($urandom_range(0, 3) == 0), 1'($urandom),
             ($urandom_range(0, 3) == 0) ? 32'h7fff_ffff : $urandom,
             ($urandom_range(0, 3) == 0) ? 32'h8000_0000 : $urandom,
             12'($urandom), 4'($urandom));
      PC_in = $urandom;
      signed_immediate_in = 24'($urandom);
      branch_taken_in = 1'($urandom);
      tick();
    end

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_checks, n_fail);
    $finish;
  end

endmodule
